// File: rtl/pipeline_pkg.sv
// Shared definitions for the MEM-stage load/store engine: funct3 width
// codes (RISC-V encoding) and the access FSM state encoding.
package pipeline_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_MERGE  = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  // Halfword access (signed or unsigned) needs 2-byte alignment.
  function automatic logic f3_is_half(input logic [2:0] f3);
    return (f3 == F3_H) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus the data-memory bus of the load/store
// engine. The unit takes the slave view; the requester/memory side takes
// the master view.
interface mem_access_unit_if;

  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_write;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic        o_rsp_err;
  logic [31:0] o_mem_addr;
  logic        o_mem_write;
  logic [31:0] o_mem_data;
  logic [31:0] i_mem_data;

  modport slave (
    input  i_req_valid, i_req_write, i_req_funct3, i_req_addr, i_req_wdata,
    input  i_rsp_ready, i_mem_data,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
    output o_mem_addr, o_mem_write, o_mem_data
  );

  modport master (
    output i_req_valid, i_req_write, i_req_funct3, i_req_addr, i_req_wdata,
    output i_rsp_ready, i_mem_data,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_err,
    input  o_mem_addr, o_mem_write, o_mem_data
  );

endinterface

// File: rtl/mem_lane_format.sv
// Combinational lane handling: extracts and extends the addressed byte or
// halfword of a read word, and splices store data into a previously read
// word for sub-word stores.
module mem_lane_format
  import pipeline_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rd_word,
  input  logic [31:0] merge_word,
  input  logic [31:0] st_data,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic        [7:0]  lane_b;
  logic        [15:0] lane_h;
  logic signed [7:0]  lane_b_s;
  logic signed [15:0] lane_h_s;

  // Load path: select the lane, then sign- or zero-extend by funct3.
  always_comb begin
    case (byte_off)
      2'd0:    lane_b = rd_word[7:0];
      2'd1:    lane_b = rd_word[15:8];
      2'd2:    lane_b = rd_word[23:16];
      default: lane_b = rd_word[31:24];
    endcase
    lane_h   = byte_off[1] ? rd_word[31:16] : rd_word[15:0];
    lane_b_s = $signed(lane_b);
    lane_h_s = $signed(lane_h);
    case (funct3)
      F3_B:    ld_data = 32'(lane_b_s);
      F3_H:    ld_data = 32'(lane_h_s);
      F3_BU:   ld_data = {24'h0, lane_b};
      F3_HU:   ld_data = {16'h0, lane_h};
      default: ld_data = rd_word;
    endcase
  end

  // Store path: replace only the addressed lane(s) of the read-back word.
  always_comb begin
    st_word = merge_word;
    case (funct3[1:0])
      2'b00: begin
        case (byte_off)
          2'd0:    st_word[7:0]   = st_data[7:0];
          2'd1:    st_word[15:8]  = st_data[7:0];
          2'd2:    st_word[23:16] = st_data[7:0];
          default: st_word[31:24] = st_data[7:0];
        endcase
      end
      2'b01: begin
        if (byte_off[1]) st_word[31:16] = st_data[15:0];
        else             st_word[15:0]  = st_data[15:0];
      end
      default: st_word = st_data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine. One request at a time: accept and check in
// IDLE, touch memory in ACCESS (and MERGE for read-modify-write sub-word
// stores), then hold the response in RESP until it is consumed. The memory
// write strobe is decoded from state so an asynchronous reset drops it
// immediately; a sub-word store only writes in MERGE, so aborting earlier
// leaves memory untouched.
module mem_access_unit
  import pipeline_pkg::*;
#(
  parameter int MEM_BYTES = 128
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clk_enable,
  mem_access_unit_if.slave bus
);

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic        req_misalign;
  logic        req_illegal;
  logic        req_range;
  logic        req_err;
  logic        word_store;
  logic        mem_write;
  logic [31:0] ld_data;
  logic [31:0] st_word;

  mem_lane_format u_lane (
    .funct3     (funct3_q),
    .byte_off   (addr_q[1:0]),
    .rd_word    (bus.i_mem_data),
    .merge_word (merge_q),
    .st_data    (wdata_q),
    .ld_data    (ld_data),
    .st_word    (st_word)
  );

  // Legality of the incoming request, evaluated on the raw request fields.
  always_comb begin
    req_misalign = (f3_is_half(bus.i_req_funct3) && bus.i_req_addr[0]) ||
                   ((bus.i_req_funct3 == F3_W) && (bus.i_req_addr[1:0] != 2'b00));
    if (bus.i_req_write)
      req_illegal = !((bus.i_req_funct3 == F3_B) || (bus.i_req_funct3 == F3_H) ||
                      (bus.i_req_funct3 == F3_W));
    else
      req_illegal = (bus.i_req_funct3 == 3'b011) || (bus.i_req_funct3 == 3'b110) ||
                    (bus.i_req_funct3 == 3'b111);
    req_range = {bus.i_req_addr[31:2], 2'b00} > 32'(MEM_BYTES - 4);
    req_err   = req_misalign || req_illegal || req_range;
  end

  // Next state and next values of the request latch and response registers.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    merge_d    = merge_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_req_valid) begin
          write_d    = bus.i_req_write;
          funct3_d   = bus.i_req_funct3;
          addr_d     = bus.i_req_addr;
          wdata_d    = bus.i_req_wdata;
          rsp_data_d = 32'h0;
          rsp_err_d  = req_err;
          state_d    = req_err ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (!write_q) begin
          rsp_data_d = ld_data;
          state_d    = ST_RESP;
        end else if (funct3_q == F3_W) begin
          state_d = ST_RESP;
        end else begin
          merge_d = bus.i_mem_data;
          state_d = ST_MERGE;
        end
      end
      ST_MERGE: state_d = ST_RESP;
      ST_RESP: begin
        if (bus.i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; everything holds while the clock enable is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      write_q    <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      merge_q    <= 32'h0;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
    end else if (i_clk_enable) begin
      state_q    <= state_d;
      write_q    <= write_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      merge_q    <= merge_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Handshake and memory-bus outputs decoded from state and latched fields.
  always_comb begin
    word_store      = write_q && (funct3_q == F3_W);
    mem_write       = (state_q == ST_MERGE) || ((state_q == ST_ACCESS) && word_store);
    bus.o_req_ready = (state_q == ST_IDLE);
    bus.o_rsp_valid = (state_q == ST_RESP);
    bus.o_rsp_data  = rsp_data_q;
    bus.o_rsp_err   = rsp_err_q;
    bus.o_mem_addr  = {addr_q[31:2], 2'b00};
    bus.o_mem_write = mem_write;
    bus.o_mem_data  = mem_write ? ((state_q == ST_MERGE) ? st_word : wdata_q) : 32'h0;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a byte-array data memory answers the bus, and a
// separate byte-array reference model predicts results, errors, latency and
// write counts from the load/store rules.
module tb_mem_access_unit;

  localparam int MEM_BYTES = 128;

  logic clk;
  logic rst_n;
  logic ce;
  logic init_req;

  int tests_run;
  int tests_failed;
  int write_cnt;
  logic [31:0] last_wdata;

  logic [7:0] mem     [0:MEM_BYTES-1];
  logic [7:0] ref_mem [0:MEM_BYTES-1];
  logic [6:0] ma;

  mem_access_unit_if bus ();

  mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_clk_enable (ce),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ma = bus.o_mem_addr[6:0];
  assign bus.i_mem_data = (bus.o_mem_addr < 32'(MEM_BYTES)) ?
                          {mem[ma + 7'd3], mem[ma + 7'd2], mem[ma + 7'd1], mem[ma]} : 32'h0;

  // Data memory: word write on an enabled clock edge.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'(i);
    end else if (ce && bus.o_mem_write) begin
      if (bus.o_mem_addr < 32'(MEM_BYTES)) begin
        mem[ma]         <= bus.o_mem_data[7:0];
        mem[ma + 7'd1]  <= bus.o_mem_data[15:8];
        mem[ma + 7'd2]  <= bus.o_mem_data[23:16];
        mem[ma + 7'd3]  <= bus.o_mem_data[31:24];
      end
      write_cnt  <= write_cnt + 1;
      last_wdata <= bus.o_mem_data;
    end
  end

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic ref_err(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    logic ill;
    int   sz;
    sz = ref_size(f3);
    if (wr) ill = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    ill = (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    return ill || ((a % sz) != 0) || ((a & 32'hFFFF_FFFC) > 32'(MEM_BYTES - 4));
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    longint v;
    int sz;
    sz = ref_size(f3);
    v = 0;
    for (int i = 0; i < sz; i++)
      v = v + (longint'(ref_mem[int'((a + i) % MEM_BYTES)]) << (8 * i));
    if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
      v = v - (longint'(1) << (8 * sz));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int sz;
    sz = ref_size(f3);
    for (int i = 0; i < sz; i++)
      ref_mem[int'((a + i) % MEM_BYTES)] = 8'(wd >> (8 * i));
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
  endfunction

  // ---------------- drivers ----------------
  task automatic init_mem();
    init_req = 1'b1;
    @(posedge clk);
    #1 init_req = 1'b0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'(i);
  endtask

  task automatic send_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.o_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.i_req_valid  = 1'b1;
    bus.i_req_write  = wr;
    bus.i_req_funct3 = f3;
    bus.i_req_addr   = a;
    bus.i_req_wdata  = wd;
    @(posedge clk);
    #1 bus.i_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.o_rsp_valid && lat < 20);
  endtask

  task automatic take_rsp();
    bus.i_rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.i_rsp_ready = 1'b0;
  endtask

  task automatic xact(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] d, output logic e,
                      output int lat, output int nwr);
    int w0;
    w0 = write_cnt;
    send_req(wr, f3, a, wd);
    wait_rsp(lat);
    d = bus.o_rsp_data;
    e = bus.o_rsp_err;
    take_rsp();
    nwr = write_cnt - w0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.o_req_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_req_ready got %b want 1", bus.o_req_ready);
    end
    tests_run++;
    if (bus.o_rsp_valid !== 1'b0 || bus.o_rsp_err !== 1'b0 || bus.o_rsp_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_rsp got valid=%b err=%b data=%h want 0/0/0",
               bus.o_rsp_valid, bus.o_rsp_err, bus.o_rsp_data);
    end
    tests_run++;
    if (bus.o_mem_write !== 1'b0 || bus.o_mem_addr !== 32'h0 || bus.o_mem_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_mem got write=%b addr=%h data=%h want 0/0/0",
               bus.o_mem_write, bus.o_mem_addr, bus.o_mem_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus.o_req_ready !== 1'b1 || bus.o_rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_idle got ready=%b valid=%b want 1/0",
               bus.o_req_ready, bus.o_rsp_valid);
    end
  endtask

  task automatic test_load_word();
    logic [31:0] d; logic e; int lat, nwr;
    xact(1'b0, 3'b010, 32'h4, 32'h0, d, e, lat, nwr);
    tests_run++;
    if (d !== 32'h07060504 || e !== 1'b0 || lat != 2 || nwr != 0) begin
      tests_failed++;
      $display("FAIL lw_0x4 got data=%h err=%b lat=%0d writes=%0d want 07060504/0/2/0",
               d, e, lat, nwr);
    end
  endtask

  task automatic test_sub_word();
    logic [31:0] d; logic e; int lat, nwr;
    xact(1'b1, 3'b000, 32'h1, 32'h80, d, e, lat, nwr);
    ref_store(3'b000, 32'h1, 32'h80);
    tests_run++;
    if (d !== 32'h0 || e !== 1'b0 || lat != 3 || nwr != 1) begin
      tests_failed++;
      $display("FAIL sb_0x1 got data=%h err=%b lat=%0d writes=%0d want 0/0/3/1", d, e, lat, nwr);
    end
    xact(1'b0, 3'b000, 32'h1, 32'h0, d, e, lat, nwr);
    tests_run++;
    if (d !== 32'hFFFFFF80 || e !== 1'b0 || lat != 2) begin
      tests_failed++; $display("FAIL lb_0x1 got data=%h err=%b lat=%0d want ffffff80/0/2", d, e, lat);
    end
    xact(1'b0, 3'b100, 32'h1, 32'h0, d, e, lat, nwr);
    tests_run++;
    if (d !== 32'h00000080 || e !== 1'b0) begin
      tests_failed++; $display("FAIL lbu_0x1 got data=%h err=%b want 00000080/0", d, e);
    end
    xact(1'b0, 3'b010, 32'h0, 32'h0, d, e, lat, nwr);
    tests_run++;
    if (d !== 32'h03028000) begin
      tests_failed++; $display("FAIL lw_0x0_after_sb got %h want 03028000", d);
    end
  endtask

  task automatic test_sh_merge();
    logic [31:0] d; logic e; int lat, nwr;
    xact(1'b1, 3'b001, 32'h6, 32'h1234BEEF, d, e, lat, nwr);
    ref_store(3'b001, 32'h6, 32'h1234BEEF);
    tests_run++;
    if (nwr != 1 || last_wdata !== 32'hBEEF0504 || lat != 3 || e !== 1'b0) begin
      tests_failed++;
      $display("FAIL sh_0x6 got writes=%0d wdata=%h lat=%0d err=%b want 1/beef0504/3/0",
               nwr, last_wdata, lat, e);
    end
    xact(1'b0, 3'b010, 32'h4, 32'h0, d, e, lat, nwr);
    tests_run++;
    if (d !== 32'hBEEF0504) begin
      tests_failed++; $display("FAIL lw_0x4_after_sh got %h want beef0504", d);
    end
  endtask

  task automatic test_errors();
    logic        wrs [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [2:0]  f3s [6] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101};
    logic [31:0] ads [6] = '{32'h2, 32'h3, 32'h80, 32'h0, 32'h0, 32'h1};
    logic [31:0] d; logic e; int lat, nwr;
    for (int i = 0; i < 6; i++) begin
      xact(wrs[i], f3s[i], ads[i], 32'hFFFF_FFFF, d, e, lat, nwr);
      tests_run++;
      if (e !== 1'b1 || d !== 32'h0 || lat != 1 || nwr != 0) begin
        tests_failed++;
        $display("FAIL err_case%0d got err=%b data=%h lat=%0d writes=%0d want 1/0/1/0",
                 i, e, d, lat, nwr);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d; int lat;
    exp_d = ref_load(3'b010, 32'h8);
    send_req(1'b0, 3'b010, 32'h8, 32'h0);
    wait_rsp(lat);
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_data !== exp_d || bus.o_req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL backpressure_cyc%0d got valid=%b data=%h ready=%b want 1/%h/0",
                 c, bus.o_rsp_valid, bus.o_rsp_data, bus.o_req_ready, exp_d);
      end
      @(negedge clk);
    end
    take_rsp();
    @(negedge clk);
    tests_run++;
    if (bus.o_req_ready !== 1'b1 || bus.o_rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_release got ready=%b valid=%b want 1/0",
               bus.o_req_ready, bus.o_rsp_valid);
    end
  endtask

  task automatic test_clk_enable();
    int w0, n, lat;
    logic [31:0] d;
    w0 = write_cnt;
    send_req(1'b1, 3'b000, 32'h9, 32'h5A);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.o_mem_write && n < 10);
    tests_run++;
    if (n >= 10) begin
      tests_failed++; $display("FAIL ce_reach_merge got timeout want o_mem_write");
    end
    ce = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests_run++;
      if (bus.o_mem_write !== 1'b1 || bus.o_rsp_valid !== 1'b0 || write_cnt != w0) begin
        tests_failed++;
        $display("FAIL ce_frozen_cyc%0d got write=%b valid=%b writes=%0d want 1/0/0",
                 c, bus.o_mem_write, bus.o_rsp_valid, write_cnt - w0);
      end
    end
    ce = 1'b1;
    wait_rsp(lat);
    ref_store(3'b000, 32'h9, 32'h5A);
    tests_run++;
    if (lat != 1 || write_cnt - w0 != 1 || last_wdata !== ref_word(8)) begin
      tests_failed++;
      $display("FAIL ce_release got lat=%0d writes=%0d wdata=%h want 1/1/%h",
               lat, write_cnt - w0, last_wdata, ref_word(8));
    end
    take_rsp();
    begin
      logic e; int nwr;
      xact(1'b0, 3'b000, 32'h9, 32'h0, d, e, lat, nwr);
    end
    tests_run++;
    if (d !== 32'h0000005A) begin
      tests_failed++; $display("FAIL ce_lb_0x9 got %h want 0000005a", d);
    end
  endtask

  task automatic test_reset_mid_rmw();
    int w0, n, lat, nwr;
    logic [31:0] d; logic e;
    init_mem();
    send_req(1'b1, 3'b001, 32'h4, 32'h1234);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.o_mem_write && n < 10);
    tests_run++;
    if (n >= 10) begin
      tests_failed++; $display("FAIL rst_reach_merge got timeout want o_mem_write");
    end
    w0 = write_cnt;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.o_mem_write !== 1'b0 || bus.o_req_ready !== 1'b1 || bus.o_rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_merge got write=%b ready=%b valid=%b want 0/1/0",
               bus.o_mem_write, bus.o_req_ready, bus.o_rsp_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (write_cnt != w0 || {mem[7], mem[6], mem[5], mem[4]} !== 32'h07060504) begin
      tests_failed++;
      $display("FAIL rst_mem_untouched got writes=%0d word=%h want 0/07060504",
               write_cnt - w0, {mem[7], mem[6], mem[5], mem[4]});
    end
    xact(1'b0, 3'b010, 32'h4, 32'h0, d, e, lat, nwr);
    tests_run++;
    if (d !== 32'h07060504 || e !== 1'b0) begin
      tests_failed++; $display("FAIL rst_lw_0x4 got %h err=%b want 07060504/0", d, e);
    end
  endtask

  task automatic test_random();
    logic        wr, e, e_exp;
    logic [2:0]  f3;
    logic [31:0] a, wd, d, d_exp;
    int          lat, nwr, lat_exp, nwr_exp;
    for (int t = 0; t < 300; t++) begin
      wr = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                       : (wr ? 3'($urandom_range(0, 2))
                                             : 3'($urandom_range(0, 5)));
      a  = 32'($urandom_range(0, 135));
      if ($urandom_range(0, 2) != 0) a = a & ~32'(ref_size(f3) - 1);
      wd = $urandom;
      e_exp   = ref_err(wr, f3, a);
      d_exp   = (wr || e_exp) ? 32'h0 : ref_load(f3, a);
      lat_exp = e_exp ? 1 : ((wr && f3[1:0] != 2'b10) ? 3 : 2);
      nwr_exp = (!e_exp && wr) ? 1 : 0;
      xact(wr, f3, a, wd, d, e, lat, nwr);
      if (!e_exp && wr) ref_store(f3, a, wd);
      tests_run++;
      if (d !== d_exp || e !== e_exp || lat != lat_exp || nwr != nwr_exp) begin
        tests_failed++;
        $display("FAIL rand%0d wr=%b f3=%0d a=%h got data=%h err=%b lat=%0d wr#=%0d want %h/%b/%0d/%0d",
                 t, wr, f3, a, d, e, lat, nwr, d_exp, e_exp, lat_exp, nwr_exp);
      end
    end
    begin
      int bad;
      bad = 0;
      for (int i = 0; i < MEM_BYTES; i++) if (mem[i] !== ref_mem[i]) bad++;
      tests_run++;
      if (bad != 0) begin
        tests_failed++; $display("FAIL final_mem_image got %0d differing bytes want 0", bad);
      end
    end
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    write_cnt        = 0;
    last_wdata       = 32'h0;
    init_req         = 1'b0;
    ce               = 1'b1;
    rst_n            = 1'b0;
    bus.i_req_valid  = 1'b0;
    bus.i_req_write  = 1'b0;
    bus.i_req_funct3 = 3'b000;
    bus.i_req_addr   = 32'h0;
    bus.i_req_wdata  = 32'h0;
    bus.i_rsp_ready  = 1'b0;
    test_reset();
    init_mem();
    test_load_word();
    test_sub_word();
    test_sh_merge();
    test_errors();
    test_backpressure();
    test_clk_enable();
    test_reset_mid_rmw();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
